// File: rtl/canvas_pkg.sv
// Shared canvas definitions for the framebuffer writer and the display reader.
// Pure types and constants; no logic, no latency.
package canvas_pkg;
    localparam int FB_W      = 160;
    localparam int FB_H      = 120;
    localparam int ADDR_W    = 15;
    localparam int COLOUR_W  = 12;
    localparam int FB_PIXELS = FB_W * FB_H;

    typedef logic [COLOUR_W-1:0] colour_t;

    localparam colour_t BG_COLOUR = 12'hFFF;

    typedef enum logic [1:0] {IDLE, PAINT, CLEAR, DONE} canvas_state_e;
endpackage

// File: rtl/fb_addr_calc.sv
// Combinational (x, y) -> linear framebuffer address plus in-bounds flag.
// Zero latency; no flow control. Address is only meaningful when in_bounds is set.
module fb_addr_calc
    import canvas_pkg::*;
(
    input  logic [8:0]        x,
    input  logic [7:0]        y,
    output logic [ADDR_W-1:0] addr,
    output logic              in_bounds
);
    // y*160 as (y<<7)+(y<<5); widest reachable value still fits in 15 bits
    assign addr      = {y, 7'b0} + {2'b0, y, 5'b0} + {6'b0, x};
    assign in_bounds = (x < 9'(FB_W)) && (y < 8'(FB_H));
endmodule

// File: rtl/canvas_writer.sv
// Paint/clear engine emitting one framebuffer write slot per clock, first slot 1 cycle after accept.
// No back-pressure on the write port; requests seen while busy are dropped. Optional erase: CANVAS_ERASE_EN.
module canvas_writer
    import canvas_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic [7:0]          cursor_x,
    input  logic [6:0]          cursor_y,
    input  logic [COLOUR_W-1:0] brush_colour,
    input  logic [1:0]          brush_size,
    input  logic                paint_req,
    input  logic                clear_req,
`ifdef CANVAS_ERASE_EN
    input  logic                erase,
`endif
    output logic                wr_en,
    output logic [ADDR_W-1:0]   wr_addr,
    output logic [COLOUR_W-1:0] wr_data,
    output logic                busy,
    output logic                done
);
    canvas_state_e       state_q, state_d;
    logic [7:0]          cx_q, cx_d;
    logic [6:0]          cy_q, cy_d;
    colour_t             colour_q, colour_d;
    logic [1:0]          last_q, last_d;
    logic [1:0]          dx_q, dx_d, dy_q, dy_d;
    logic [ADDR_W-1:0]   clr_addr_q, clr_addr_d;
    logic                wr_en_q, wr_en_d;
    logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
    colour_t             wr_data_q, wr_data_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;

    logic [1:0]          ndx, ndy;
    logic [8:0]          px;
    logic [7:0]          py;
    logic [ADDR_W-1:0]   pix_addr;
    logic                pix_in;
    colour_t             paint_colour;

    always_comb begin
`ifdef CANVAS_ERASE_EN
        paint_colour = erase ? BG_COLOUR : brush_colour;
`else
        paint_colour = brush_colour;
`endif
    end

    // Offsets of the slot to be registered next; the address unit sees the raw
    // cursor when accepting so the first write lands one cycle after the request.
    always_comb begin
        ndx = (dx_q == last_q) ? 2'd0 : dx_q + 2'd1;
        ndy = (dx_q == last_q) ? dy_q + 2'd1 : dy_q;
        if (state_q == IDLE) begin
            px = {1'b0, cursor_x};
            py = {1'b0, cursor_y};
        end else begin
            px = {1'b0, cx_q} + {7'b0, ndx};
            py = {1'b0, cy_q} + {6'b0, ndy};
        end
    end

    fb_addr_calc u_paint_addr (
        .x         (px),
        .y         (py),
        .addr      (pix_addr),
        .in_bounds (pix_in)
    );

    // The state register runs one cycle ahead of the registered outputs:
    // DONE covers the final write slot, so done=1 coincides with IDLE.
    always_comb begin
        state_d    = state_q;
        cx_d       = cx_q;
        cy_d       = cy_q;
        colour_d   = colour_q;
        last_d     = last_q;
        dx_d       = dx_q;
        dy_d       = dy_q;
        clr_addr_d = clr_addr_q;
        wr_en_d    = 1'b0;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        busy_d     = 1'b0;
        done_d     = 1'b0;
        case (state_q)
            IDLE: begin
                if (clear_req) begin
                    state_d    = CLEAR;
                    dx_d       = 2'd0;
                    dy_d       = 2'd0;
                    clr_addr_d = '0;
                    wr_en_d    = 1'b1;
                    wr_addr_d  = '0;
                    wr_data_d  = BG_COLOUR;
                    busy_d     = 1'b1;
                end else if (paint_req) begin
                    state_d    = (brush_size == 2'd0) ? DONE : PAINT;
                    cx_d       = cursor_x;
                    cy_d       = cursor_y;
                    colour_d   = paint_colour;
                    last_d     = brush_size;
                    dx_d       = 2'd0;
                    dy_d       = 2'd0;
                    clr_addr_d = '0;
                    wr_en_d    = pix_in;
                    wr_addr_d  = pix_addr;
                    wr_data_d  = paint_colour;
                    busy_d     = 1'b1;
                end
            end
            PAINT: begin
                dx_d      = ndx;
                dy_d      = ndy;
                wr_en_d   = pix_in;
                wr_addr_d = pix_addr;
                wr_data_d = colour_q;
                busy_d    = 1'b1;
                if (ndx == last_q && ndy == last_q) begin
                    state_d = DONE;
                end
            end
            CLEAR: begin
                clr_addr_d = clr_addr_q + 1'b1;
                wr_en_d    = 1'b1;
                wr_addr_d  = clr_addr_q + 1'b1;
                wr_data_d  = BG_COLOUR;
                busy_d     = 1'b1;
                if (clr_addr_q + 1'b1 == ADDR_W'(FB_PIXELS - 1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            cx_q       <= '0;
            cy_q       <= '0;
            colour_q   <= '0;
            last_q     <= '0;
            dx_q       <= '0;
            dy_q       <= '0;
            clr_addr_q <= '0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cx_q       <= cx_d;
            cy_q       <= cy_d;
            colour_q   <= colour_d;
            last_q     <= last_d;
            dx_q       <= dx_d;
            dy_q       <= dy_d;
            clr_addr_q <= clr_addr_d;
            wr_en_q    <= wr_en_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign wr_en   = wr_en_q;
    assign wr_addr = wr_addr_q;
    assign wr_data = wr_data_q;
    assign busy    = busy_q;
    assign done    = done_q;
endmodule

// File: tb/tb_canvas_writer.sv
// Randomised self-checking bench for canvas_writer against a slot-by-slot canvas model.
module tb_canvas_writer;
    localparam int W   = 160;
    localparam int H   = 120;
    localparam logic [11:0] BG = 12'hFFF;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  cursor_x;
    logic [6:0]  cursor_y;
    logic [11:0] brush_colour;
    logic [1:0]  brush_size;
    logic        paint_req;
    logic        clear_req;
    logic        erase;
    logic        wr_en;
    logic [14:0] wr_addr;
    logic [11:0] wr_data;
    logic        busy;
    logic        done;

    int checks   = 0;
    int failures = 0;

    canvas_writer dut (
        .clk          (clk),
        .reset        (reset),
        .cursor_x     (cursor_x),
        .cursor_y     (cursor_y),
        .brush_colour (brush_colour),
        .brush_size   (brush_size),
        .paint_req    (paint_req),
        .clear_req    (clear_req),
`ifdef CANVAS_ERASE_EN
        .erase        (erase),
`endif
        .wr_en        (wr_en),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .busy         (busy),
        .done         (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Issue one command (called #1 after a posedge with the DUT idle) and
    // check every slot, the done cycle and two idle cycles after it.
    task automatic do_cmd(input bit clr, input bit both, input logic [7:0] x, input logic [6:0] y,
                          input logic [11:0] col, input logic [1:0] bs, input bit er, input bit pulse_mid);
        int s, n, j, px, py, eaddr;
        bit een;
        logic [11:0] ecol;
        s    = int'(bs) + 1;
        n    = clr ? W * H : s * s;
        ecol = clr ? BG : col;
`ifdef CANVAS_ERASE_EN
        if (!clr && er) ecol = BG;
`endif
        cursor_x     = x;
        cursor_y     = y;
        brush_colour = col;
        brush_size   = bs;
        erase        = er;
        clear_req    = clr;
        paint_req    = !clr || both;
        @(posedge clk);
        #1;
        paint_req = 1'b0;
        clear_req = 1'b0;
        for (int c = 1; c <= n + 1; c++) begin
            @(negedge clk);
            if (c <= n) begin
                j = c - 1;
                if (clr) begin
                    een   = 1'b1;
                    eaddr = j;
                end else begin
                    px    = int'(x) + j % s;
                    py    = int'(y) + j / s;
                    een   = (px < W) && (py < H);
                    eaddr = py * W + px;
                end
                check("busy", busy, 1);
                check("done_early", done, 0);
                check("wr_en", wr_en, een);
                if (een) begin
                    check("wr_addr", wr_addr, eaddr);
                    check("wr_data", wr_data, ecol);
                end
                if (pulse_mid && c == n / 2) paint_req = 1'b1;
                if (pulse_mid && c == n / 2 + 3) paint_req = 1'b0;
            end else begin
                check("done", done, 1);
                check("busy_at_done", busy, 0);
                check("wr_en_at_done", wr_en, 0);
            end
        end
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            check("idle_busy", busy, 0);
            check("idle_done", done, 0);
            check("idle_wr_en", wr_en, 0);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        bit found;
        reset        = 1'b1;
        cursor_x     = '0;
        cursor_y     = '0;
        brush_colour = '0;
        brush_size   = '0;
        paint_req    = 1'b0;
        clear_req    = 1'b0;
        erase        = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_wr_en", wr_en, 0);
        check("rst_wr_addr", wr_addr, 0);
        check("rst_wr_data", wr_data, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Size-1 paint at (10,5) -> addr 810
        do_cmd(0, 0, 8'd10, 7'd5, 12'hF00, 2'd0, 0, 0);
        // Corner clip: 4x4 at (158,118)
        do_cmd(0, 0, 8'd158, 7'd118, 12'h123, 2'd3, 0, 0);
        // Fully off-canvas anchor
        do_cmd(0, 0, 8'd200, 7'd125, 12'h0AB, 2'd2, 0, 0);
        // Full clear
        do_cmd(1, 0, 8'd0, 7'd0, 12'h000, 2'd0, 0, 0);
        // Both requests high -> clear wins; paint pulsed mid-clear is ignored
        do_cmd(1, 1, 8'd3, 7'd3, 12'h456, 2'd1, 0, 1);
`ifdef CANVAS_ERASE_EN
        do_cmd(0, 0, 8'd0, 7'd0, 12'h0F0, 2'd1, 1, 0);
`endif

        // Held request level is re-accepted at the edge ending the done cycle
        cursor_x     = 8'd1;
        cursor_y     = 7'd1;
        brush_colour = 12'h777;
        brush_size   = 2'd0;
        erase        = 1'b0;
        paint_req    = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("hold_c1_busy", busy, 1);
        check("hold_c1_addr", wr_addr, 161);
        @(negedge clk);
        check("hold_c2_done", done, 1);
        @(negedge clk);
        check("hold_c3_busy", busy, 1);
        check("hold_c3_wr_en", wr_en, 1);
        paint_req = 1'b0;
        @(negedge clk);
        check("hold_c4_done", done, 1);
        @(negedge clk);
        check("hold_c5_busy", busy, 0);
        @(posedge clk);
        #1;

        // Reset in the middle of a clear
        clear_req = 1'b1;
        @(posedge clk);
        #1;
        clear_req = 1'b0;
        found = 1'b0;
        for (int c = 0; c < 1000 && !found; c++) begin
            @(negedge clk);
            if (wr_en && wr_addr == 15'd500) found = 1'b1;
        end
        check("reach_addr_500", found, 1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("midrst_wr_en", wr_en, 0);
        check("midrst_busy", busy, 0);
        check("midrst_done", done, 0);
        @(posedge clk);
        #1;
        do_cmd(0, 0, 8'd20, 7'd30, 12'h3C3, 2'd1, 0, 0);

        // Randomised paints biased towards the right/bottom edges
        for (int i = 0; i < 40; i++) begin
            logic [7:0]  rx;
            logic [6:0]  ry;
            logic [11:0] rc;
            logic [1:0]  rs;
            bit          re;
            rx = $urandom_range(0, 1) ? 8'($urandom_range(150, 255)) : 8'($urandom_range(0, 159));
            ry = $urandom_range(0, 1) ? 7'($urandom_range(110, 127)) : 7'($urandom_range(0, 119));
            rc = 12'($urandom);
            rs = 2'($urandom_range(0, 3));
            re = 1'($urandom_range(0, 1));
            do_cmd(0, 0, rx, ry, rc, rs, re, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/canvas_writer.md
# canvas_writer

Framebuffer write engine for the 160×120, 12-bit-colour paint canvas. It is the write-side counterpart of the VGA scan-out reader: it accepts paint and clear commands and turns them into a stream of one-pixel-per-clock writes on the framebuffer RAM's write port. Paint stamps a square brush anchored at the cursor; clear fills the whole canvas with the background colour.

## Interface
- FB_W, 160, canvas width in pixels
- FB_H, 120, canvas height in pixels
- ADDR_W, 15, framebuffer address width
- COLOUR_W, 12, pixel colour width (4:4:4 RGB)
- BG_COLOUR, 12'hFFF, colour written by clear (and erase)

- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- cursor_x  in  8  brush anchor column (top-left of brush)
- cursor_y  in  7  brush anchor row
- brush_colour  in  12  paint colour
- brush_size  in  2  brush edge S = brush_size+1 (1..4 px)
- paint_req  in  1  level; start a brush stamp
- clear_req  in  1  level; start a full-canvas clear
- erase  in  1  present only with CANVAS_ERASE_EN
- wr_en  out  1  framebuffer write strobe
- wr_addr  out  15  linear address, y*FB_W + x
- wr_data  out  12  pixel colour
- busy  out  1  command in progress
- done  out  1  one-cycle completion pulse

## Operation
- States: IDLE, PAINT, CLEAR, DONE.
- IDLE: sample requests at every edge. clear_req has priority over paint_req when both are high. On acceptance, latch cursor_x, cursor_y, colour, S; zero dx, dy, clr_addr.
- PAINT: visit (dx, dy) in raster order, with dx fastest, over S×S cycles.
  - Each cycle with x = cursor_x+dx < FB_W and y = cursor_y+dy < FB_H issues wr_en=1, wr_addr = y*160+x, wr_data = latched colour.
  - A clipped pixel gives wr_en=0 but still takes its cycle, so duration is always S×S.
  - An anchor fully off-canvas gives S×S cycles with no writes.
- CLEAR: wr_addr walks 0..FB_W*FB_H−1 (0..19199), one write per cycle, wr_data = BG_COLOUR.
- DONE: one cycle with done=1 and busy=0, then IDLE.
- Requests arriving while busy or during DONE are ignored, not queued. A request still high in IDLE is accepted again, so the issuer must drop the level after done.
- Address arithmetic: y*160 = (y<<7)+(y<<5), computed at 15 bits with no truncation. The maximum is 19199.
- Reset mid-operation: the next cycle is IDLE, with wr_en=0, busy=0, done=0. No partial write completes.

## Timing
- All outputs are registered.
- Reset values: wr_en=0, wr_addr=0, wr_data=0, busy=0, done=0, state IDLE.
- Request sampled at edge k:
  - busy is high for cycles k+1 .. k+N, where N = S×S (paint) or 19200 (clear).
  - Write slots occupy cycles k+1 .. k+N, one per cycle, gap-free.
  - done is high in cycle k+N+1.
  - Earliest next acceptance is the edge ending cycle k+N+1.
- Paint latency from request edge to first write is 1 cycle. Clear takes 19200 cycles.
- The write port is on clk and is independent of the display's read port (dual-port RAM). No handshake or back-pressure exists on the write side.

## Configuration
- CANVAS_ERASE_EN defined:
  - Adds the erase input, latched with paint_req.
  - A paint accepted with erase=1 writes BG_COLOUR instead of brush_colour.
  - Geometry and timing are otherwise identical.
- Undefined: the erase port is absent, and paint always writes brush_colour.

## Structure
- canvas_pkg holds:
  - FB_W, FB_H, ADDR_W, COLOUR_W, and FB_PIXELS = 19200.
  - colour_t (logic [11:0]).
  - The state enum {IDLE, PAINT, CLEAR, DONE}.
  - BG_COLOUR default.
- canvas_pkg is shared with the display reader.
- Sub-module fb_addr_calc: combinational (x, y) → linear address plus in-bounds flag. It is instantiated once for the paint path and is reusable by cursor logic.

## Test plan
- Size-1 paint: paint_req at (10,5), colour 12'hF00, brush_size=0.
  - Expect exactly one write, addr 810, data F00.
  - done one cycle after the write; busy for 1 cycle.
- Corner clip: brush_size=3 at (158,118).
  - Expect 16 busy cycles.
  - Writes only to addrs 19038, 19039, 19198, 19199; the other 12 slots have wr_en=0.
- Full clear: clear_req pulse.
  - Expect 19200 consecutive writes, addr 0..19199, data 12'hFFF.
  - done in the following cycle; no write past 19199.
- Priority and ignore:
  - paint_req and clear_req high together → CLEAR runs.
  - paint_req pulsed mid-clear → no extra writes after done.
- Reset mid-clear at wr_addr 500 → the next cycle has wr_en=0, busy=0, done=0, and a new paint is accepted normally.
- With CANVAS_ERASE_EN: paint at (0,0), size 2, erase=1, colour 12'h0F0 → 4 writes to addrs 0, 1, 160, 161 with data 12'hFFF.
